irq_trap_ctrl: RTL and testbench

Parametrised interrupt/trap controller that generalises the CPU mode/interrupt logic to NUM_IRQ local interrupt lines. It synchronises the lines and latches them as edge- or level-triggered pending bits, then arbitrates by fixed priority with mode-gated global enables and per-source S-mode delegation. It issues a held trap request to the WB stage with a frozen cause and vectored trap_pc, and owns the privilege-mode register, including the mret/sret return paths.

---
 rtl/irq_trap_ctrl_if.sv | 13 +
 rtl/irq_trap_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_irq_trap_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/irq_trap_ctrl_if.sv
// Trap handshake between the interrupt controller and the WB stage:
// held request with frozen cause/target, single-cycle acknowledge.
interface irq_trap_ctrl_if #(
    parameter int PC_SZ = 32
);
    logic             trap_req;
    logic             trap_ack;
    logic [5:0]       trap_cause;
    logic [PC_SZ-3:0] trap_pc;

    modport master (output trap_req, trap_cause, trap_pc, input trap_ack);
    modport slave  (input trap_req, trap_cause, trap_pc, output trap_ack);
endinterface

// File: rtl/irq_trap_ctrl.sv
// Local interrupt controller: per-line sync/pending lanes, fixed-priority
// arbitration with mode-gated enables and delegation, trap FSM, privilege mode.
module irq_trap_lane #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_in,
    input  logic reset_n_in,
    input  logic irq_raw,
    input  logic edge_cfg,
    input  logic clr,
    output logic pend
);
    logic [SYNC_STAGES-1:0] sync;
    logic                   hist;
    logic                   synced;

    assign synced = sync[SYNC_STAGES-1];

    // A fresh rising edge beats a clear landing in the same cycle.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            sync <= '0;
            hist <= 1'b0;
            pend <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], irq_raw};
            hist <= synced;
            if (!edge_cfg)
                pend <= synced;
            else if (synced && !hist)
                pend <= 1'b1;
            else if (clr)
                pend <= 1'b0;
        end
    end
endmodule

module irq_trap_ctrl #(
    parameter int NUM_IRQ     = 16,
    parameter int SYNC_STAGES = 2,
    parameter int PC_SZ       = 32,
    parameter int RSZ         = 32
) (
    input  logic               clk_in,
    input  logic               reset_n_in,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic [NUM_IRQ-1:0] irq_edge_cfg,
    input  logic [NUM_IRQ-1:0] irq_en,
    input  logic [NUM_IRQ-1:0] irq_deleg,
    input  logic [NUM_IRQ-1:0] irq_clr,
    input  logic               mstatus_mie,
    input  logic               sstatus_sie,
    input  logic [RSZ-1:0]     mtvec,
    input  logic [RSZ-1:0]     stvec,
    input  logic [1:0]         mpp,
    input  logic               spp,
    input  logic               mret,
    input  logic               sret,
    input  logic               exception_flag,
    input  logic               exception_deleg,
    irq_trap_ctrl_if.master    trap_bus,
    output logic [1:0]         mode,
    output logic [1:0]         nxt_mode,
    output logic [NUM_IRQ-1:0] pending
);
    localparam int PW = PC_SZ - 2;

    typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

    state_t             state, state_nxt;
    logic [NUM_IRQ-1:0] s_tgt, glb_en, eligible, ack_clr, lane_clr;
    logic               win_any, win_s, ack_fire, exc_s;
    logic [5:0]         win_idx, win_cause;
    logic [RSZ-1:0]     win_tvec;
    logic [PW-1:0]      win_pc, exc_pc;
    logic [5:0]         idx_q, cause_q;
    logic [1:0]         tgt_q;
    logic [PW-1:0]      pc_q;

    function automatic logic [PW-1:0] tvec_base(input logic [RSZ-1:0] t);
        return PW'(t >> 2);
    endfunction

    irq_trap_lane #(.SYNC_STAGES(SYNC_STAGES)) u_lane [NUM_IRQ-1:0] (
        .clk_in     (clk_in),
        .reset_n_in (reset_n_in),
        .irq_raw    (irq_in),
        .edge_cfg   (irq_edge_cfg),
        .clr        (lane_clr),
        .pend       (pending)
    );

    assign ack_fire = (state == REQ) && trap_bus.trap_ack && !exception_flag;

    for (genvar g = 0; g < NUM_IRQ; g++) begin : g_clr
        assign ack_clr[g] = ack_fire && (idx_q == 6'(g));
    end
    assign lane_clr = irq_clr | ack_clr;

    // Delegated sources are masked outright in M-mode.
    always_comb begin
        s_tgt  = '0;
        glb_en = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            s_tgt[i] = irq_deleg[i] && (mode <= 2'd1);
            if (irq_deleg[i] && mode == 2'd3)
                glb_en[i] = 1'b0;
            else if (s_tgt[i])
                glb_en[i] = (mode == 2'd0) || sstatus_sie;
            else
                glb_en[i] = (mode != 2'd3) || mstatus_mie;
        end
    end

    assign eligible = pending & irq_en & glb_en;

    always_comb begin
        win_any = 1'b0;
        win_idx = '0;
        win_s   = 1'b0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                win_any = 1'b1;
                win_idx = 6'(i);
                win_s   = s_tgt[i];
            end
        end
    end

    assign win_cause = 6'd16 + win_idx;
    assign win_tvec  = win_s ? stvec : mtvec;
    assign win_pc    = (win_tvec[1:0] == 2'b01) ? tvec_base(win_tvec) + PW'(win_cause)
                                                 : tvec_base(win_tvec);
    assign exc_s     = exception_deleg && (mode <= 2'd1);
    assign exc_pc    = exc_s ? tvec_base(stvec) : tvec_base(mtvec);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (win_any && !exception_flag) state_nxt = REQ;
            REQ:     if (exception_flag) state_nxt = IDLE;
                     else if (trap_bus.trap_ack) state_nxt = HOLD;
            HOLD:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        nxt_mode = mode;
        if (exception_flag)
            nxt_mode = exc_s ? 2'd1 : 2'd3;
        else if (ack_fire)
            nxt_mode = tgt_q;
        else if (mret)
            nxt_mode = (mpp == 2'd2) ? 2'd3 : mpp;
        else if (sret)
            nxt_mode = {1'b0, spp};
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state   <= IDLE;
            mode    <= 2'd3;
            idx_q   <= '0;
            cause_q <= '0;
            tgt_q   <= 2'd3;
            pc_q    <= '0;
        end else begin
            state <= state_nxt;
            mode  <= nxt_mode;
            if (state == IDLE && state_nxt == REQ) begin
                idx_q   <= win_idx;
                cause_q <= win_cause;
                tgt_q   <= win_s ? 2'd1 : 2'd3;
                pc_q    <= win_pc;
            end
        end
    end

    assign trap_bus.trap_req   = (state == REQ);
    assign trap_bus.trap_cause = cause_q;
    assign trap_bus.trap_pc    = exception_flag ? exc_pc : pc_q;
endmodule

// File: tb/tb_irq_trap_ctrl.sv
// Directed plus randomized checks of irq_trap_ctrl; requests are scored
// against a queue of expected {cause, trap_pc} filled by the stimulus side.
module tb_irq_trap_ctrl;
    localparam int N   = 16;
    localparam int SS  = 2;
    localparam int PCS = 32;
    localparam int RSZ = 32;

    logic           clk_in = 1'b0;
    logic           reset_n_in = 1'b0;
    logic [N-1:0]   irq_in, irq_edge_cfg, irq_en, irq_deleg, irq_clr;
    logic           mstatus_mie, sstatus_sie;
    logic [RSZ-1:0] mtvec, stvec;
    logic [1:0]     mpp;
    logic           spp, mret, sret, exception_flag, exception_deleg;
    logic [1:0]     mode, nxt_mode;
    logic [N-1:0]   pending;

    irq_trap_ctrl_if #(.PC_SZ(PCS)) bus ();

    irq_trap_ctrl #(.NUM_IRQ(N), .SYNC_STAGES(SS), .PC_SZ(PCS), .RSZ(RSZ)) dut (
        .clk_in(clk_in), .reset_n_in(reset_n_in), .irq_in(irq_in),
        .irq_edge_cfg(irq_edge_cfg), .irq_en(irq_en), .irq_deleg(irq_deleg),
        .irq_clr(irq_clr), .mstatus_mie(mstatus_mie), .sstatus_sie(sstatus_sie),
        .mtvec(mtvec), .stvec(stvec), .mpp(mpp), .spp(spp), .mret(mret),
        .sret(sret), .exception_flag(exception_flag),
        .exception_deleg(exception_deleg), .trap_bus(bus.master),
        .mode(mode), .nxt_mode(nxt_mode), .pending(pending)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [5:0]  cause;
        logic [29:0] pc;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    logic req_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, want);
        end
    endtask

    // Monitor: every fresh trap request must match the oldest expectation.
    always @(negedge clk_in) begin
        exp_t e;
        if (bus.trap_req === 1'b1 && !req_prev) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_req: got cause=%0d pc=%0h want no request",
                         bus.trap_cause, bus.trap_pc);
            end else begin
                e = exp_q.pop_front();
                check("req_cause", 32'(bus.trap_cause), 32'(e.cause));
                check("req_pc", 32'(bus.trap_pc), 32'(e.pc));
            end
        end
        req_prev <= (bus.trap_req === 1'b1);
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic push_exp(input int c, input logic [29:0] pc);
        exp_q.push_back('{cause: 6'(c), pc: pc});
    endtask

    task automatic pulse(input logic [N-1:0] m);
        irq_in = irq_in | m;
        step();
        irq_in = irq_in & ~m;
    endtask

    task automatic wait_req(input string name);
        int k = 0;
        while (bus.trap_req !== 1'b1 && k < 20) begin
            step();
            k++;
        end
        check(name, 32'(bus.trap_req), 32'd1);
    endtask

    task automatic ack();
        bus.trap_ack = 1'b1;
        step();
        bus.trap_ack = 1'b0;
    endtask

    task automatic set_mode(input logic [1:0] m);
        mpp  = m;
        mret = 1'b1;
        step();
        mret = 1'b0;
    endtask

    task automatic expect_quiet(input string name, input int n);
        int seen = 0;
        repeat (n) begin
            step();
            if (bus.trap_req === 1'b1) seen++;
        end
        check(name, 32'(seen), 32'd0);
    endtask

    function automatic logic [29:0] exp_pc(input logic [31:0] tv, input int cause);
        logic [31:0] b;
        b = tv >> 2;
        if (tv[1:0] == 2'b01) b = b + 32'(cause);
        return b[29:0];
    endfunction

    // Reference arbitration straight from the enable/delegation rules.
    function automatic void pick(input logic [N-1:0] p, input int md, output int w, output bit s);
        w = -1;
        s = 1'b0;
        for (int i = 0; i < N; i++) begin
            bit d, ok;
            d = irq_deleg[i];
            if (!p[i] || !irq_en[i] || w >= 0) continue;
            if (d && md == 3) ok = 1'b0;
            else if (d && md <= 1) ok = (md == 0) || sstatus_sie;
            else ok = (md < 3) || mstatus_mie;
            if (ok) begin
                w = i;
                s = d && (md <= 1);
            end
        end
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        irq_in = '0; irq_edge_cfg = 16'h7FFF; irq_en = '0; irq_deleg = '0; irq_clr = '0;
        mstatus_mie = 1'b0; sstatus_sie = 1'b0; mtvec = '0; stvec = '0;
        mpp = 2'd0; spp = 1'b0; mret = 1'b0; sret = 1'b0;
        exception_flag = 1'b0; exception_deleg = 1'b0; bus.trap_ack = 1'b0;
        step(2);
        check("rst_req", 32'(bus.trap_req), 32'd0);
        check("rst_mode", 32'(mode), 32'd3);
        check("rst_pending", 32'(pending), 32'd0);
        check("rst_cause", 32'(bus.trap_cause), 32'd0);
        check("rst_pc", 32'(bus.trap_pc), 32'd0);
        reset_n_in = 1'b1;
        step();

        // Edge source 3, direct vector
        mstatus_mie = 1'b1; mtvec = 32'h100; irq_en[3] = 1'b1;
        push_exp(19, 30'h40);
        pulse(16'h0008);
        step();
        check("t1_pend_early", 32'(pending[3]), 32'd0);
        step();
        check("t1_pend_set", 32'(pending[3]), 32'd1);
        check("t1_req_not_yet", 32'(bus.trap_req), 32'd0);
        wait_req("t1_req");
        ack();
        check("t1_pend_clr", 32'(pending[3]), 32'd0);
        check("t1_hold_req", 32'(bus.trap_req), 32'd0);
        check("t1_mode", 32'(mode), 32'd3);
        step();

        // Vectored M vector, source 0
        mtvec = 32'h201; irq_en[0] = 1'b1;
        push_exp(16, 30'h90);
        pulse(16'h0001);
        wait_req("t2_req");
        ack();
        step();

        // Priority: sources 2 and 5 together
        mtvec = 32'h100; irq_en[2] = 1'b1; irq_en[5] = 1'b1;
        push_exp(18, 30'h40);
        push_exp(21, 30'h40);
        pulse(16'h0024);
        wait_req("t3_req_a");
        ack();
        check("t3_hold", 32'(bus.trap_req), 32'd0);
        check("t3_pend5_kept", 32'(pending[5]), 32'd1);
        wait_req("t3_req_b");
        ack();
        step();

        // Level line 15: follows the line, ignores irq_clr
        irq_in[15] = 1'b1;
        step(3);
        check("lvl_high", 32'(pending[15]), 32'd1);
        irq_clr[15] = 1'b1;
        step();
        irq_clr[15] = 1'b0;
        check("lvl_clr_ignored", 32'(pending[15]), 32'd1);
        irq_in[15] = 1'b0;
        step(3);
        check("lvl_low", 32'(pending[15]), 32'd0);

        // Delegation
        set_mode(2'd0);
        irq_deleg[1] = 1'b1; stvec = 32'h400; sstatus_sie = 1'b0; irq_en[1] = 1'b1;
        push_exp(17, 30'h100);
        pulse(16'h0002);
        wait_req("t4_req");
        ack();
        check("t4_mode_s", 32'(mode), 32'd1);
        step();
        pulse(16'h0002);
        step(2);
        check("t4_pend", 32'(pending[1]), 32'd1);
        expect_quiet("t4_quiet_s_nosie", 6);
        set_mode(2'd3);
        check("t4_mode_m", 32'(mode), 32'd3);
        expect_quiet("t4_quiet_m", 6);
        irq_clr[1] = 1'b1;
        step();
        irq_clr[1] = 1'b0;
        check("t4_clr", 32'(pending[1]), 32'd0);
        irq_deleg = '0;

        // Exception while requesting
        mtvec = 32'h101; irq_en[4] = 1'b1;
        push_exp(20, 30'h54);
        push_exp(20, 30'h54);
        pulse(16'h0010);
        wait_req("t5_req");
        step();
        exception_flag = 1'b1; exception_deleg = 1'b0;
        #1;
        check("t5_exc_nxt_mode", 32'(nxt_mode), 32'd3);
        check("t5_exc_pc", 32'(bus.trap_pc), 32'h40);
        step();
        check("t5_req_drop", 32'(bus.trap_req), 32'd0);
        check("t5_pend_kept", 32'(pending[4]), 32'd1);
        exception_flag = 1'b0;
        wait_req("t5_reissue");
        ack();
        step();
        set_mode(2'd0);
        exception_flag = 1'b1; exception_deleg = 1'b1;
        #1;
        check("t5_dexc_nxt_mode", 32'(nxt_mode), 32'd1);
        check("t5_dexc_pc", 32'(bus.trap_pc), 32'h100);
        exception_flag = 1'b0; exception_deleg = 1'b0;
        #1;

        // Returns and asynchronous reset mid-request
        set_mode(2'd2);
        check("t6_mret_rsvd", 32'(mode), 32'd3);
        spp = 1'b0; sret = 1'b1;
        step();
        sret = 1'b0;
        check("t6_sret", 32'(mode), 32'd0);
        irq_en[6] = 1'b1;
        push_exp(22, 30'h56);
        pulse(16'h0040);
        wait_req("t6_req");
        step();
        #1;
        reset_n_in = 1'b0;
        #1;
        check("t6_async_req", 32'(bus.trap_req), 32'd0);
        check("t6_async_mode", 32'(mode), 32'd3);
        check("t6_async_pend", 32'(pending), 32'd0);
        step();
        reset_n_in = 1'b1;
        step();

        // Randomized sessions against the rule-level model
        irq_edge_cfg = '1;
        for (int it = 0; it < 30; it++) begin
            logic [N-1:0] mpend;
            logic [1:0]   mp;
            int           m_mode;
            irq_en      = N'($urandom);
            irq_deleg   = N'($urandom);
            mstatus_mie = 1'($urandom_range(0, 1));
            sstatus_sie = 1'($urandom_range(0, 1));
            mtvec       = ($urandom & ~32'h3) | 32'($urandom_range(0, 1));
            stvec       = ($urandom & ~32'h3) | 32'($urandom_range(0, 1));
            mp          = 2'($urandom_range(0, 3));
            set_mode(mp);
            m_mode = (mp == 2'd2) ? 3 : int'(mp);
            check("rnd_mode_set", 32'(mode), 32'(m_mode));
            mpend = N'($urandom);
            if (mpend == '0) mpend = 16'h0001;
            pulse(mpend);
            step(2);
            check("rnd_pend", 32'(pending), 32'(mpend));
            for (int k = 0; k <= N; k++) begin
                int w;
                bit ws;
                pick(mpend, m_mode, w, ws);
                if (w < 0) begin
                    expect_quiet("rnd_quiet", 5);
                    break;
                end
                push_exp(16 + w, exp_pc(ws ? stvec : mtvec, 16 + w));
                wait_req("rnd_req");
                step($urandom_range(0, 3));
                ack();
                mpend[w] = 1'b0;
                m_mode   = ws ? 1 : 3;
                check("rnd_mode_ack", 32'(mode), 32'(m_mode));
                check("rnd_hold", 32'(bus.trap_req), 32'd0);
                check("rnd_pend_ack", 32'(pending), 32'(mpend));
            end
            irq_clr = '1;
            step();
            irq_clr = '0;
            check("rnd_clr_all", 32'(pending), 32'd0);
        end

        step(2);
        check("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
